// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter for the bit-serial link: loads a WIDTH-bit word, shifts it out one bit per clock.
// Latency: first bit valid the cycle after the load edge, done pulses the cycle after the last bit (WIDTH+1 cycles after load).
// Backpressure: ready is high in IDLE and DONE only; a load while ready is low is dropped, never queued.
module piso_serial_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             done
);

    // Counter must be able to hold WIDTH itself, so it never wraps within a frame.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;

    // State, shift register and bit counter; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; outputs depend only on registered state, never on load or data_in.
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        cnt_nxt      = cnt;
        ready        = 1'b0;
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    shreg_nxt = data_in;
                    cnt_nxt   = CNT_FULL;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                serial_valid = 1'b1;
                serial_out   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                frame_start  = (cnt == CNT_FULL);
                // Zero fill keeps the register clean once the frame has drained.
                shreg_nxt    = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                         : {1'b0, shreg[WIDTH-1:1]};
                cnt_nxt      = cnt - CNT_LAST;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                done  = 1'b1;
                ready = 1'b1;
                // A load here starts the next frame after a single gap cycle.
                if (load) begin
                    shreg_nxt = data_in;
                    cnt_nxt   = CNT_FULL;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
module tb_piso_serial_tx;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] data_in;

    logic m_ready, m_out, m_valid, m_fs, m_done;
    logic l_ready, l_out, l_valid, l_fs, l_done;

    piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .ready(m_ready), .serial_out(m_out), .serial_valid(m_valid),
        .frame_start(m_fs), .done(m_done)
    );

    piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .ready(l_ready), .serial_out(l_out), .serial_valid(l_valid),
        .frame_start(l_fs), .done(l_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected per-cycle frame bit for both bit orders (both instances see the same loads).
    typedef struct packed {
        logic mb;
        logic lb;
        logic first;
        logic last;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] wq[$];
    int           busy;
    logic         exp_done;
    int           errors;
    int           checks;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: a load is honoured only if no frame is occupying the link;
    // an accepted word blocks further loads for the WIDTH edges of its frame.
    always @(posedge clk) begin
        if (!rst) begin
            if (load && busy == 0) begin
                for (int i = 0; i < W; i++) begin
                    exp_t e;
                    e.mb    = data_in[W-1-i];
                    e.lb    = data_in[i];
                    e.first = (i == 0);
                    e.last  = (i == W - 1);
                    q.push_back(e);
                end
                wq.push_back(data_in);
                busy = W;
            end else if (busy > 0) begin
                busy = busy - 1;
            end
        end
    end

    // Receiving D-flip-flop chains, one per bit order.
    logic [W-1:0] rx_m, rx_l;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= '0;
            rx_l <= '0;
        end else begin
            if (m_valid) rx_m <= {rx_m[W-2:0], m_out};
            if (l_valid) rx_l <= {l_out, rx_l[W-1:1]};
        end
    end

    // Monitor: pop an expected bit whenever the link should carry one and compare everything.
    exp_t         cur;
    logic         ev;
    logic [W-1:0] wexp;
    always @(negedge clk) begin
        if (!rst) begin
            ev = (q.size() > 0);
            if (ev) cur = q.pop_front();
            else    cur = '0;
            chk("valid_msb", 32'(m_valid), 32'(ev));
            chk("valid_lsb", 32'(l_valid), 32'(ev));
            chk("out_msb",   32'(m_out),   32'(ev & cur.mb));
            chk("out_lsb",   32'(l_out),   32'(ev & cur.lb));
            chk("fs_msb",    32'(m_fs),    32'(ev & cur.first));
            chk("fs_lsb",    32'(l_fs),    32'(ev & cur.first));
            chk("ready_msb", 32'(m_ready), 32'(busy == 0));
            chk("ready_lsb", 32'(l_ready), 32'(busy == 0));
            chk("done_msb",  32'(m_done),  32'(exp_done));
            chk("done_lsb",  32'(l_done),  32'(exp_done));
            if (exp_done) begin
                if (wq.size() > 0) begin
                    wexp = wq.pop_front();
                    chk("rx_word_msb", 32'(rx_m), 32'(wexp));
                    chk("rx_word_lsb", 32'(rx_l), 32'(wexp));
                end else begin
                    chk("rx_word_queue", 32'(wq.size()), 32'd1);
                end
            end
            exp_done = ev & cur.last;
        end
    end

    // Assert reset mid-cycle, flush the model, and confirm outputs settle before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        wq.delete();
        busy     = 0;
        exp_done = 1'b0;
        #1;
        chk("rst_ready_msb", 32'(m_ready), 32'd1);
        chk("rst_ready_lsb", 32'(l_ready), 32'd1);
        chk("rst_valid_msb", 32'(m_valid), 32'd0);
        chk("rst_valid_lsb", 32'(l_valid), 32'd0);
        chk("rst_out_msb",   32'(m_out),   32'd0);
        chk("rst_out_lsb",   32'(l_out),   32'd0);
        chk("rst_fs_msb",    32'(m_fs),    32'd0);
        chk("rst_fs_lsb",    32'(l_fs),    32'd0);
        chk("rst_done_msb",  32'(m_done),  32'd0);
        chk("rst_done_lsb",  32'(l_done),  32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Present a word for one cycle, then scramble data_in to prove it was captured.
    task automatic send(input logic [W-1:0] w);
        @(negedge clk);
        load    = 1'b1;
        data_in = w;
        @(negedge clk);
        load    = 1'b0;
        data_in = W'($urandom);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        busy     = 0;
        exp_done = 1'b0;
        load     = 1'b0;
        data_in  = '0;
        rst      = 1'b0;
        #1;
        do_reset();

        // Single frames in both bit orders.
        send(8'hA5);
        repeat (12) @(negedge clk);
        send(8'h3C);
        repeat (12) @(negedge clk);

        // Load attempt during bit 3 of an all-zero frame must be ignored.
        send(8'h00);
        repeat (2) @(negedge clk);
        load    = 1'b1;
        data_in = 8'hFF;
        @(negedge clk);
        load    = 1'b0;
        repeat (12) @(negedge clk);

        // Second load lands exactly in the done cycle.
        send(8'h81);
        repeat (W) @(negedge clk);
        load    = 1'b1;
        data_in = 8'h7E;
        @(negedge clk);
        load    = 1'b0;
        repeat (14) @(negedge clk);

        // Reset during bit 5 aborts the frame; the next frame must be intact.
        send(8'hC3);
        repeat (4) @(posedge clk);
        #2;
        do_reset();
        send(8'h5A);
        repeat (12) @(negedge clk);

        // Random load traffic, including loads while busy and back-to-back frames.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            load    = ($urandom_range(0, 3) == 0);
            data_in = W'($urandom);
        end
        @(negedge clk);
        load = 1'b0;
        repeat (24) @(negedge clk);

        chk("model_bits_drained",  32'(q.size()),  32'd0);
        chk("model_words_drained", 32'(wq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
